// File: rtl/rf_write_arbiter_if.sv
// Handshake and write-port bundle for rf_write_arbiter.
// RF_ARB_BYPASS_EN adds the byp_a/byp_hit/byp_data lookup signals.
interface rf_write_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_wd;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_wd;

    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_a3;
    logic [DATA_WIDTH-1:0] rf_wd;
    logic [CNT_W-1:0]      fifo_cnt;

`ifdef RF_ARB_BYPASS_EN
    logic [ADDR_WIDTH-1:0] byp_a;
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] byp_data;
`endif

    modport master (
        output alu_valid, alu_rd, alu_wd,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_wd,
        input  lsu_ready,
        input  rf_we, rf_a3, rf_wd, fifo_cnt
`ifdef RF_ARB_BYPASS_EN
        ,
        output byp_a,
        input  byp_hit, byp_data
`endif
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wd,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_wd,
        output lsu_ready,
        output rf_we, rf_a3, rf_wd, fifo_cnt
`ifdef RF_ARB_BYPASS_EN
        ,
        input  byp_a,
        output byp_hit, byp_data
`endif
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between ALU (priority) and a buffered LSU stream.
// RF_ARB_BYPASS_EN adds a combinational lookup over queued loads and the in-flight write.
module rf_write_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    rf_write_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_WIDTH-1:0] fifo_rd_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wd_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STV_W-1:0]      starve_q, starve_d;

    logic                  rf_we_q;
    logic [ADDR_WIDTH-1:0] rf_a3_q;
    logic [DATA_WIDTH-1:0] rf_wd_q;

    logic                  fifo_empty, fifo_full;
    logic                  force_lsu;
    logic                  alu_ready, lsu_ready;
    logic                  grant_alu, grant_lsu, grant_any;
    logic                  enq;
    logic [ADDR_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0] win_wd;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign force_lsu  = !fifo_empty && (starve_q == STV_W'(STARVE_LIMIT));

    assign alu_ready  = !rst && !force_lsu;
    // Uses the current count: a full FIFO refuses even while it pops.
    assign lsu_ready  = !rst && !fifo_full;

    assign grant_alu  = bus.alu_valid && alu_ready;
    assign grant_lsu  = !rst && !fifo_empty && (force_lsu || !bus.alu_valid);
    assign grant_any  = grant_alu || grant_lsu;
    assign enq        = bus.lsu_valid && lsu_ready;

    assign win_rd = grant_lsu ? fifo_rd_q[head_q] : bus.alu_rd;
    assign win_wd = grant_lsu ? fifo_wd_q[head_q] : bus.alu_wd;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({enq, grant_lsu})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (grant_lsu || fifo_empty) begin
            starve_d = '0;
        end else if (grant_alu && (starve_q != STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd_q[tail_q] <= bus.lsu_rd;
            fifo_wd_q[tail_q] <= bus.lsu_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            rf_we_q  <= 1'b0;
            rf_a3_q  <= '0;
            rf_wd_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            if (enq) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (grant_lsu) begin
                head_q <= head_q + PTR_W'(1);
            end
            // Writes to x0 are consumed but never reach the register file.
            rf_we_q <= grant_any && (win_rd != '0);
            if (grant_any) begin
                rf_a3_q <= win_rd;
                rf_wd_q <= win_wd;
            end
        end
    end

    assign bus.alu_ready = alu_ready;
    assign bus.lsu_ready = lsu_ready;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_a3     = rf_a3_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.fifo_cnt  = cnt_q;

`ifdef RF_ARB_BYPASS_EN
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [PTR_W-1:0]      byp_idx;

    // Scan oldest to youngest so the tail-most FIFO match overrides the in-flight write.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = '0;
        if (bus.byp_a != '0) begin
            if (rf_we_q && (rf_a3_q == bus.byp_a)) begin
                byp_hit  = 1'b1;
                byp_data = rf_wd_q;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                byp_idx = head_q + PTR_W'(i);
                if ((CNT_W'(i) < cnt_q) && (fifo_rd_q[byp_idx] == bus.byp_a)) begin
                    byp_hit  = 1'b1;
                    byp_data = fifo_wd_q[byp_idx];
                end
            end
        end
    end

    assign bus.byp_hit  = byp_hit;
    assign bus.byp_data = byp_data;
`endif

    a_one_grant: assert property (@(posedge clk) disable iff (rst) !(grant_alu && grant_lsu));
    a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_W'(FIFO_DEPTH));
    a_starve_range: assert property (@(posedge clk) disable iff (rst)
                                     starve_q <= STV_W'(STARVE_LIMIT));
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected register-file writes are queued by the
// stimulus and checked by an independent monitor on every rf_we pulse.
module tb_rf_write_arbiter;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    rf_write_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(2)) bus ();

    rf_write_arbiter #(
        .ADDR_WIDTH  (5),
        .DATA_WIDTH  (32),
        .FIFO_DEPTH  (2),
        .STARVE_LIMIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] wd);
        exp_q.push_back({rd, wd});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of requests, check the combinational readies, then advance.
    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                       input logic ear, input logic elr, input string tag);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_wd    = awd;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_wd    = lwd;
        #1;
        check({tag, ".alu_ready"}, {31'd0, bus.alu_ready}, {31'd0, ear});
        check({tag, ".lsu_ready"}, {31'd0, bus.lsu_ready}, {31'd0, elr});
        tick();
    endtask

    task automatic idle(input int n);
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        repeat (n) tick();
    endtask

    always @(negedge clk) begin
        if (bus.rf_we === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got rd=%0d wd=%h, required no write",
                         bus.rf_a3, bus.rf_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.rf_a3 !== e.rd || bus.rf_wd !== e.wd) begin
                    n_err++;
                    $display("FAIL rf_write: got rd=%0d wd=%h, required rd=%0d wd=%h",
                             bus.rf_a3, bus.rf_wd, e.rd, e.wd);
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd4;
        bus.alu_wd    = 32'h1111_1111;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = '0;
        bus.lsu_wd    = '0;
`ifdef RF_ARB_BYPASS_EN
        bus.byp_a     = '0;
`endif

        // Reset held two cycles with a live ALU request.
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst.alu_ready", {31'd0, bus.alu_ready}, 32'd0);
            check("rst.lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
            tick();
        end
        rst           = 1'b0;
        bus.alu_valid = 1'b0;
        #1;
        check("rst.rf_we", {31'd0, bus.rf_we}, 32'd0);
        check("rst.rf_a3", {27'd0, bus.rf_a3}, 32'd0);
        check("rst.rf_wd", bus.rf_wd, 32'd0);
        check("rst.fifo_cnt", {30'd0, bus.fifo_cnt}, 32'd0);
        tick();

        // ALU only, including back-to-back beats.
        expect_wr(5'd5, 32'hDEAD_BEEF);
        cyc(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 1, 1, "alu0");
        bus.alu_valid = 1'b0;
        tick();
        check("alu.rf_we_drop", {31'd0, bus.rf_we}, 32'd0);
        check("alu.rf_a3_hold", {27'd0, bus.rf_a3}, 32'd5);
        expect_wr(5'd10, 32'h0000_0001);
        cyc(1, 5'd10, 32'h0000_0001, 0, 5'd0, 32'd0, 1, 1, "alu1");
        expect_wr(5'd31, 32'hFFFF_FFFF);
        cyc(1, 5'd31, 32'hFFFF_FFFF, 0, 5'd0, 32'd0, 1, 1, "alu2");
        idle(2);

        // Fill to full under ALU pressure; third load waits for space.
        expect_wr(5'd20, 32'hA000_0000);
        cyc(1, 5'd20, 32'hA000_0000, 1, 5'd1, 32'h101, 1, 1, "fill0");
        expect_wr(5'd21, 32'hA000_0001);
        cyc(1, 5'd21, 32'hA000_0001, 1, 5'd2, 32'h102, 1, 1, "fill1");
        check("fill.cnt_full", {30'd0, bus.fifo_cnt}, 32'd2);
        expect_wr(5'd22, 32'hA000_0002);
        cyc(1, 5'd22, 32'hA000_0002, 1, 5'd3, 32'h103, 1, 0, "fill2");
        expect_wr(5'd23, 32'hA000_0003);
        cyc(1, 5'd23, 32'hA000_0003, 1, 5'd3, 32'h103, 1, 0, "fill3");
        expect_wr(5'd1, 32'h101);
        cyc(1, 5'd24, 32'hA000_0004, 1, 5'd3, 32'h103, 0, 0, "fill4");
        expect_wr(5'd24, 32'hA000_0004);
        cyc(1, 5'd24, 32'hA000_0004, 1, 5'd3, 32'h103, 1, 1, "fill5");
        check("fill.cnt_refill", {30'd0, bus.fifo_cnt}, 32'd2);
        expect_wr(5'd2, 32'h102);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 0, "drain0");
        expect_wr(5'd3, 32'h103);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 1, "drain1");
        check("drain.cnt", {30'd0, bus.fifo_cnt}, 32'd0);
        idle(2);

        // Starvation: three ALU wins, then the load is forced through.
        expect_wr(5'd10, 32'hB000_0000);
        cyc(1, 5'd10, 32'hB000_0000, 1, 5'd7, 32'h777, 1, 1, "stv0");
        expect_wr(5'd11, 32'hB000_0001);
        cyc(1, 5'd11, 32'hB000_0001, 0, 5'd0, 32'd0, 1, 1, "stv1");
        expect_wr(5'd12, 32'hB000_0002);
        cyc(1, 5'd12, 32'hB000_0002, 0, 5'd0, 32'd0, 1, 1, "stv2");
        expect_wr(5'd13, 32'hB000_0003);
        cyc(1, 5'd13, 32'hB000_0003, 0, 5'd0, 32'd0, 1, 1, "stv3");
        expect_wr(5'd7, 32'h777);
        cyc(1, 5'd14, 32'hB000_0004, 0, 5'd0, 32'd0, 0, 1, "stv4");
        expect_wr(5'd14, 32'hB000_0004);
        cyc(1, 5'd14, 32'hB000_0004, 0, 5'd0, 32'd0, 1, 1, "stv5");
        check("stv.cnt", {30'd0, bus.fifo_cnt}, 32'd0);
        idle(2);

        // x0 destinations are consumed without a write.
        cyc(1, 5'd0, 32'h1234, 1, 5'd0, 32'h5678, 1, 1, "x0_alu");
        check("x0.rf_we_alu", {31'd0, bus.rf_we}, 32'd0);
        check("x0.cnt_one", {30'd0, bus.fifo_cnt}, 32'd1);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 1, "x0_lsu");
        check("x0.rf_we_lsu", {31'd0, bus.rf_we}, 32'd0);
        check("x0.cnt_zero", {30'd0, bus.fifo_cnt}, 32'd0);
        idle(2);

        // Reset with two loads queued discards them.
        expect_wr(5'd15, 32'hC000_0000);
        cyc(1, 5'd15, 32'hC000_0000, 1, 5'd8, 32'h808, 1, 1, "mid0");
        expect_wr(5'd16, 32'hC000_0001);
        cyc(1, 5'd16, 32'hC000_0001, 1, 5'd9, 32'hA5, 1, 1, "mid1");
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        check("mid.cnt_full", {30'd0, bus.fifo_cnt}, 32'd2);
`ifdef RF_ARB_BYPASS_EN
        bus.byp_a = 5'd9;
        #1;
        check("byp.hit_fifo", {31'd0, bus.byp_hit}, 32'd1);
        check("byp.data_fifo", bus.byp_data, 32'hA5);
        bus.byp_a = 5'd16;
        #1;
        check("byp.hit_rf", {31'd0, bus.byp_hit}, 32'd1);
        check("byp.data_rf", bus.byp_data, 32'hC000_0001);
        bus.byp_a = 5'd0;
        #1;
        check("byp.hit_x0", {31'd0, bus.byp_hit}, 32'd0);
        check("byp.data_x0", bus.byp_data, 32'd0);
`endif
        rst = 1'b1;
        #1;
        check("mid.alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        check("mid.lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mid.cnt_reset", {30'd0, bus.fifo_cnt}, 32'd0);
        check("mid.rf_we", {31'd0, bus.rf_we}, 32'd0);
        idle(4);

        check("exp_q.drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
